fifo_status_ctrl: RTL and testbench
===================================

FIFO_STATUS_CTRL -- requirements
Module: fifo_status_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_BIT, default 4, meaning address width; depth SHALL be 2^DEPTH_BIT entries.
REQ-002 The block SHALL have parameter AFULL_TH, default 14, meaning the fill level at or above which o_afull asserts; legal range 1..2^DEPTH_BIT-1.
REQ-003 The block SHALL have parameter AEMPTY_TH, default 2, meaning the fill level at or below which o_aempty asserts; legal range 1..2^DEPTH_BIT-1.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port i_rest, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_wr_en, input, 1 bit: write request.
REQ-007 The block SHALL have port i_rd_en, input, 1 bit: read request.
REQ-008 The block SHALL have port i_flush, input, 1 bit: synchronous clear of pointers and count, leaving sticky errors intact.
REQ-009 The block SHALL have port i_clr_err, input, 1 bit: clears the sticky error flags.
REQ-010 The block SHALL have port o_addrw, output, DEPTH_BIT bits: current RAM write address.
REQ-011 The block SHALL have port o_addrr, output, DEPTH_BIT bits: current RAM read address.
REQ-012 The block SHALL have port o_wr_ok, output, 1 bit: combinational, equal to i_wr_en AND NOT o_full; the RAM write strobe.
REQ-013 The block SHALL have port o_rd_ok, output, 1 bit: combinational, equal to i_rd_en AND NOT o_empty; the RAM read strobe.
REQ-014 The block SHALL have port o_count, output, DEPTH_BIT+1 bits: registered fill level, 0..2^DEPTH_BIT.
REQ-015 The block SHALL have ports o_full, o_empty, o_afull, o_aempty, output, 1 bit each: registered status flags.
REQ-016 The block SHALL have ports o_overflow, o_underflow, output, 1 bit each: sticky error flags.

Function
REQ-017 The block SHALL keep internal write and read pointers of DEPTH_BIT+1 bits; o_addrw and o_addrr SHALL be their low DEPTH_BIT bits.
REQ-018 The block SHALL increment the write pointer by 1 on each cycle with o_wr_ok=1, and the read pointer by 1 on each cycle with o_rd_ok=1, each wrapping modulo 2^(DEPTH_BIT+1).
REQ-019 The block SHALL compute o_count as write pointer minus read pointer, modulo 2^(DEPTH_BIT+1), so that it is correct across pointer wrap-around.
REQ-020 The block SHALL assert o_full when the pointers differ only in the MSB (count = 2^DEPTH_BIT), and o_empty when the pointers are equal (count = 0).
REQ-021 The block SHALL assert o_afull when count >= AFULL_TH and o_aempty when count <= AEMPTY_TH.
REQ-022 The block SHALL register all flags and o_count from next-state pointers, so that the flags and count are mutually consistent in the same cycle and have 1-cycle latency from the accepted request.
REQ-023 On simultaneous o_wr_ok and o_rd_ok, the block SHALL move both pointers and leave the count unchanged.
REQ-024 When full and i_wr_en=1 and i_rd_en=1, the block SHALL accept only the read: count drops by 1 and o_overflow is set.
REQ-025 When empty and i_wr_en=1 and i_rd_en=1, the block SHALL accept only the write, with no fall-through: count rises by 1 and o_underflow is set.
REQ-026 The block SHALL set o_overflow in the cycle after any cycle with i_wr_en=1 and o_full=1; it SHALL hold until i_clr_err or reset.
REQ-027 The block SHALL set o_underflow in the cycle after any cycle with i_rd_en=1 and o_empty=1; it SHALL hold until i_clr_err or reset.
REQ-028 If i_clr_err and a new error event occur in the same cycle, the block SHALL let the set win.
REQ-029 When i_flush=1, the block SHALL zero both pointers next cycle and ignore any wr/rd request in that cycle; the flags SHALL become empty=1, aempty=1, full=0, afull=0.

Reset
REQ-030 When i_rest=1 at a clock edge, the block SHALL set pointers to 0, o_count=0, o_empty=1, o_aempty=1, o_full=0, o_afull=0, o_overflow=0, o_underflow=0, with priority over i_flush and all requests.
REQ-031 While i_rest=1, the block SHALL force o_wr_ok and o_rd_ok to 0.
REQ-032 A reset asserted mid-operation SHALL discard contents without any error flag being raised.

Verification (DEPTH_BIT=4, AFULL_TH=14, AEMPTY_TH=2)
REQ-033 The bench SHALL cover: reset, then 16 writes -> o_count steps 1..16; o_aempty=0 after count 3; o_afull=1 at count 14; o_full=1 at count 16.
REQ-034 The bench SHALL cover: from full, 1 write -> o_wr_ok=0, count stays 16, o_overflow=1 next cycle; then i_clr_err -> o_overflow=0.
REQ-035 The bench SHALL cover: from empty, simultaneous wr+rd -> o_rd_ok=0, count=1, o_underflow=1; from count 5, simultaneous wr+rd -> count stays 5 and both addresses advance.
REQ-036 The bench SHALL cover: 40 writes interleaved with reads holding count at 8 -> addresses wrap 15->0 and count stays 8 throughout.
REQ-037 The bench SHALL cover: at count 9, i_flush with i_wr_en=1 -> count=0, o_empty=1, o_addrw=0, and sticky flags unchanged.
REQ-038 The bench SHALL cover: at count 12, i_rest=1 with i_wr_en=1 -> all outputs at reset values next cycle, o_wr_ok=0 during reset.

Source files
------------

// File: rtl/fifo_status_ctrl.sv
// FIFO pointer/status controller: drives RAM addresses and strobes, and keeps
// registered fill level, status flags and sticky overflow/underflow flags.
module fifo_status_ctrl #(
  parameter int DEPTH_BIT = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rest,
  input  logic                 i_wr_en,
  input  logic                 i_rd_en,
  input  logic                 i_flush,
  input  logic                 i_clr_err,
  output logic [DEPTH_BIT-1:0] o_addrw,
  output logic [DEPTH_BIT-1:0] o_addrr,
  output logic                 o_wr_ok,
  output logic                 o_rd_ok,
  output logic [DEPTH_BIT:0]   o_count,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_afull,
  output logic                 o_aempty,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam logic [DEPTH_BIT:0] PTR_ONE    = (DEPTH_BIT+1)'(1);
  localparam logic [DEPTH_BIT:0] AFULL_LVL  = (DEPTH_BIT+1)'(AFULL_TH);
  localparam logic [DEPTH_BIT:0] AEMPTY_LVL = (DEPTH_BIT+1)'(AEMPTY_TH);

  logic [DEPTH_BIT:0] wptr, rptr;
  logic [DEPTH_BIT:0] wptr_nxt, rptr_nxt, count_nxt;
  logic               full_nxt, empty_nxt;

  assign o_wr_ok = i_wr_en & ~o_full  & ~i_rest;
  assign o_rd_ok = i_rd_en & ~o_empty & ~i_rest;

  assign o_addrw = wptr[DEPTH_BIT-1:0];
  assign o_addrr = rptr[DEPTH_BIT-1:0];

  // Flags come from next-state pointers so count and flags land together.
  always_comb begin
    wptr_nxt = wptr;
    rptr_nxt = rptr;
    if (i_flush) begin
      wptr_nxt = '0;
      rptr_nxt = '0;
    end else begin
      if (o_wr_ok) wptr_nxt = wptr + PTR_ONE;
      if (o_rd_ok) rptr_nxt = rptr + PTR_ONE;
    end
    count_nxt = wptr_nxt - rptr_nxt;
    empty_nxt = (wptr_nxt == rptr_nxt);
    full_nxt  = (wptr_nxt[DEPTH_BIT] != rptr_nxt[DEPTH_BIT]) &&
                (wptr_nxt[DEPTH_BIT-1:0] == rptr_nxt[DEPTH_BIT-1:0]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      wptr        <= '0;
      rptr        <= '0;
      o_count     <= '0;
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      o_afull     <= 1'b0;
      o_aempty    <= 1'b1;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      o_count  <= count_nxt;
      o_full   <= full_nxt;
      o_empty  <= empty_nxt;
      o_afull  <= (count_nxt >= AFULL_LVL);
      o_aempty <= (count_nxt <= AEMPTY_LVL);
      // A new error event wins over a simultaneous clear.
      o_overflow  <= (i_wr_en & o_full)  | (o_overflow  & ~i_clr_err);
      o_underflow <= (i_rd_en & o_empty) | (o_underflow & ~i_clr_err);
    end
  end

endmodule

// File: tb/tb_fifo_status_ctrl.sv
// Bench for fifo_status_ctrl: vector table, directed corner sequences and
// random traffic checked against an item-count reference model.
module tb_fifo_status_ctrl;
  localparam int DB = 4;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rest, wr_en, rd_en, flush, clr_err;
  logic [DB-1:0] addrw, addrr;
  logic wr_ok, rd_ok;
  logic [DB:0] count;
  logic full, empty, afull, aempty, overflow, underflow;

  fifo_status_ctrl #(.DEPTH_BIT(DB), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
    .i_clk(clk), .i_rest(rest), .i_wr_en(wr_en), .i_rd_en(rd_en),
    .i_flush(flush), .i_clr_err(clr_err),
    .o_addrw(addrw), .o_addrr(addrr), .o_wr_ok(wr_ok), .o_rd_ok(rd_ok),
    .o_count(count), .o_full(full), .o_empty(empty), .o_afull(afull),
    .o_aempty(aempty), .o_overflow(overflow), .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: number of stored items plus where next write/read lands
  int m_cnt = 0, m_wa = 0, m_ra = 0;
  bit m_ovf = 0, m_udf = 0;
  bit last_wr_ok, last_rd_ok;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("count",     int'(count),     m_cnt);
    chk("full",      int'(full),      int'(m_cnt == DEPTH));
    chk("empty",     int'(empty),     int'(m_cnt == 0));
    chk("afull",     int'(afull),     int'(m_cnt >= AF));
    chk("aempty",    int'(aempty),    int'(m_cnt <= AE));
    chk("addrw",     int'(addrw),     m_wa);
    chk("addrr",     int'(addrr),     m_ra);
    chk("overflow",  int'(overflow),  int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_udf));
  endtask

  task automatic step(input bit wr, input bit rd, input bit fl, input bit clr, input bit rst);
    bit is_full, is_empty, wok, rok;
    wr_en = wr; rd_en = rd; flush = fl; clr_err = clr; rest = rst;
    #1;
    is_full  = (m_cnt == DEPTH);
    is_empty = (m_cnt == 0);
    wok = wr && !is_full && !rst;
    rok = rd && !is_empty && !rst;
    chk("wr_ok", int'(wr_ok), int'(wok));
    chk("rd_ok", int'(rd_ok), int'(rok));
    last_wr_ok = wr_ok;
    last_rd_ok = rd_ok;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_wa = 0; m_ra = 0; m_ovf = 0; m_udf = 0;
    end else begin
      if (fl) begin
        m_cnt = 0; m_wa = 0; m_ra = 0;
      end else begin
        m_cnt = m_cnt + int'(wok) - int'(rok);
        if (wok) m_wa = (m_wa + 1) % DEPTH;
        if (rok) m_ra = (m_ra + 1) % DEPTH;
      end
      if (wr && is_full) m_ovf = 1; else if (clr) m_ovf = 0;
      if (rd && is_empty) m_udf = 1; else if (clr) m_udf = 0;
    end
    #1;
    check_model();
  endtask

  typedef struct {
    bit wr, rd, fl, clr, rst;
    int cnt;
    bit emp, ful, ovf, udf;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int pa_w, pa_r;
    bit wrap_seen;
    rest = 1; wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;

    //            wr rd fl clr rst cnt emp ful ovf udf
    tbl[0]  = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 2, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 0, 2, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[9]  = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].clr, tbl[i].rst);
      chk($sformatf("tbl%0d_count", i), int'(count),     tbl[i].cnt);
      chk($sformatf("tbl%0d_empty", i), int'(empty),     int'(tbl[i].emp));
      chk($sformatf("tbl%0d_full", i),  int'(full),      int'(tbl[i].ful));
      chk($sformatf("tbl%0d_ovf", i),   int'(overflow),  int'(tbl[i].ovf));
      chk($sformatf("tbl%0d_udf", i),   int'(underflow), int'(tbl[i].udf));
    end

    // fill from empty to full
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0, 0, 0);
      chk("fill_count", int'(count), i);
      chk("fill_aempty", int'(aempty), int'(i <= 2));
      chk("fill_afull", int'(afull), int'(i >= 14));
      chk("fill_full", int'(full), int'(i == 16));
    end

    // write while full
    step(1, 0, 0, 0, 0);
    chk("ovf_wr_ok", int'(last_wr_ok), 0);
    chk("ovf_count", int'(count), 16);
    chk("ovf_flag", int'(overflow), 1);
    step(0, 0, 0, 1, 0);
    chk("ovf_clr", int'(overflow), 0);

    // full with wr+rd: only the read is taken
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("full_wrrd_count", int'(count), 15);
    chk("full_wrrd_ovf", int'(overflow), 1);

    // empty with wr+rd: only the write is taken
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    chk("empty_wrrd_rd_ok", int'(last_rd_ok), 0);
    chk("empty_wrrd_count", int'(count), 1);
    chk("empty_wrrd_udf", int'(underflow), 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    pa_w = int'(addrw); pa_r = int'(addrr);
    step(1, 1, 0, 0, 0);
    chk("c5_count", int'(count), 5);
    chk("c5_addrw", int'(addrw), (pa_w + 1) % 16);
    chk("c5_addrr", int'(addrr), (pa_r + 1) % 16);

    // steady count 8 across address wrap
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);
    wrap_seen = 0;
    for (int i = 0; i < 40; i++) begin
      pa_w = int'(addrw);
      step(1, 1, 0, 0, 0);
      chk("wrap_count", int'(count), 8);
      if (pa_w == 15 && addrw == 0) wrap_seen = 1;
    end
    chk("wrap_seen", int'(wrap_seen), 1);

    // flush at count 9 keeps sticky flags
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
    chk("pre_flush_count", int'(count), 9);
    step(1, 0, 1, 0, 0);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_addrw", int'(addrw), 0);
    chk("flush_udf", int'(underflow), 1);
    chk("flush_ovf", int'(overflow), 0);

    // reset at count 12 with a write pending
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("rst_wr_ok", int'(last_wr_ok), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_aempty", int'(aempty), 1);
    chk("rst_addrw", int'(addrw), 0);
    chk("rst_ovf", int'(overflow), 0);

    // random traffic
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r_wr, r_rd;
      if (i < 1000)      begin r_wr = ($urandom_range(0, 3) != 0); r_rd = ($urandom_range(0, 3) == 0); end
      else if (i < 2000) begin r_wr = ($urandom_range(0, 3) == 0); r_rd = ($urandom_range(0, 3) != 0); end
      else               begin r_wr = $urandom_range(0, 1) != 0;   r_rd = $urandom_range(0, 1) != 0;   end
      step(r_wr, r_rd, $urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 249) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
